snes_pad_responder: RTL and testbench

- Device-side end of the serial game-pad link; emulates the pad that a host controller interface polls.
- Host drives latch and serial clock; this block captures a parallel button word and shifts it out on the data line, one bit per serial clock.
- Sits on PCLK; all host-side pins are asynchronous and are synchronised internally.
- Used to loop back or bench the host interface without a physical pad.

---
 rtl/snes_pad_responder.sv | 144 ++++++++++++++
 tb/tb_snes_pad_responder.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/snes_pad_responder.sv
// snes_pad_responder: emulated serial game pad that latches a button word and shifts it out LSB first.
// Define PAD_DEBOUNCE_EN to synchronise and debounce the buttons inputs before they are latched.
module snes_pad_responder #(
    parameter int NBITS       = 16,
    parameter int SYNC_STAGES = 2,
    parameter int DB_CYCLES   = 4096
) (
    input  logic                         PCLK,
    input  logic                         PRESERN,
    input  logic                         pad_latch,
    input  logic                         pad_clk,
    input  logic [NBITS-1:0]             buttons,
    output logic                         pad_data,
    output logic                         busy,
    output logic                         frame_done,
    output logic [$clog2(NBITS+1)-1:0]   bit_idx
);
    localparam int BW = $clog2(NBITS+1);

    typedef enum logic [1:0] {IDLE, LATCH, SHIFT, DONE} state_t;

    logic [SYNC_STAGES-1:0] lat_sync_q, clk_sync_q;
    logic                   lat_dly_q, clk_dly_q;
    logic                   lat_rise_q, lat_fall_q, clk_rise_q;
    logic                   lat_lvl, clk_lvl;
    logic [NBITS-1:0]       btn, sr_q, sr_d;
    logic [BW-1:0]          bit_idx_q, bit_idx_d;
    logic                   pad_data_q, busy_q, frame_done_q;
    state_t                 state_q;

    assign lat_lvl = lat_sync_q[SYNC_STAGES-1];
    assign clk_lvl = clk_sync_q[SYNC_STAGES-1];

    always_ff @(posedge PCLK or negedge PRESERN) begin
        if (!PRESERN) begin
            lat_sync_q <= '0;
            clk_sync_q <= '1;
            lat_dly_q  <= 1'b0;
            clk_dly_q  <= 1'b1;
            lat_rise_q <= 1'b0;
            lat_fall_q <= 1'b0;
            clk_rise_q <= 1'b0;
        end else begin
            lat_sync_q <= {lat_sync_q[SYNC_STAGES-2:0], pad_latch};
            clk_sync_q <= {clk_sync_q[SYNC_STAGES-2:0], pad_clk};
            lat_dly_q  <= lat_lvl;
            clk_dly_q  <= clk_lvl;
            lat_rise_q <= lat_lvl & ~lat_dly_q;
            lat_fall_q <= ~lat_lvl & lat_dly_q;
            clk_rise_q <= clk_lvl & ~clk_dly_q;
        end
    end

`ifdef PAD_DEBOUNCE_EN
    localparam int CW = $clog2(DB_CYCLES+1);

    logic [NBITS-1:0] bs1_q, bs2_q, db_q;
    logic [CW-1:0]    cnt_q [NBITS];

    // a bit flips only after the raw input disagrees for DB_CYCLES cycles in a row
    always_ff @(posedge PCLK or negedge PRESERN) begin
        if (!PRESERN) begin
            bs1_q <= '0;
            bs2_q <= '0;
            db_q  <= '0;
            for (int i = 0; i < NBITS; i++) cnt_q[i] <= '0;
        end else begin
            bs1_q <= buttons;
            bs2_q <= bs1_q;
            for (int i = 0; i < NBITS; i++) begin
                if (bs2_q[i] == db_q[i]) begin
                    cnt_q[i] <= '0;
                end else if (cnt_q[i] == CW'(DB_CYCLES-1)) begin
                    db_q[i]  <= bs2_q[i];
                    cnt_q[i] <= '0;
                end else begin
                    cnt_q[i] <= cnt_q[i] + 1'b1;
                end
            end
        end
    end

    assign btn = db_q;
`else
    logic unused_db;
    assign unused_db = ^DB_CYCLES;
    assign btn = buttons;
`endif

    assign sr_d      = sr_q >> 1;
    assign bit_idx_d = bit_idx_q + 1'b1;

    // a latch edge outranks any serial clock edge and aborts a frame in flight
    always_ff @(posedge PCLK or negedge PRESERN) begin
        if (!PRESERN) begin
            state_q      <= IDLE;
            sr_q         <= '0;
            bit_idx_q    <= '0;
            pad_data_q   <= 1'b1;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            frame_done_q <= 1'b0;
            if (lat_rise_q || (state_q == IDLE && lat_lvl)) begin
                state_q    <= LATCH;
                busy_q     <= 1'b0;
                bit_idx_q  <= '0;
                sr_q       <= btn;
                pad_data_q <= ~btn[0];
            end else begin
                case (state_q)
                    LATCH: begin
                        if (lat_fall_q) begin
                            state_q    <= SHIFT;
                            busy_q     <= 1'b1;
                            pad_data_q <= ~sr_q[0];
                        end else begin
                            sr_q       <= btn;
                            pad_data_q <= ~btn[0];
                        end
                    end
                    SHIFT: begin
                        if (clk_rise_q) begin
                            sr_q       <= sr_d;
                            pad_data_q <= ~sr_d[0];
                            bit_idx_q  <= bit_idx_d;
                            if (bit_idx_d == BW'(NBITS)) begin
                                state_q      <= DONE;
                                busy_q       <= 1'b0;
                                frame_done_q <= 1'b1;
                            end
                        end
                    end
                    default: pad_data_q <= 1'b1;
                endcase
            end
        end
    end

    assign pad_data   = pad_data_q;
    assign busy       = busy_q;
    assign frame_done = frame_done_q;
    assign bit_idx    = bit_idx_q;
endmodule

// File: tb/tb_snes_pad_responder.sv
// tb_snes_pad_responder: randomized host-side frames checked against an LSB-first, active-low pad model.
module tb_snes_pad_responder;
    localparam int NBITS = 16;
    localparam int HP    = 200;
`ifdef PAD_DEBOUNCE_EN
    localparam int DB = 16;
`else
    localparam int DB = 4096;
`endif

    logic             PCLK = 1'b0;
    logic             PRESERN = 1'b0;
    logic             pad_latch = 1'b0;
    logic             pad_clk = 1'b1;
    logic [NBITS-1:0] buttons = '0;
    logic             pad_data, busy, frame_done;
    logic [4:0]       bit_idx;

    int n_cmp = 0;
    int n_err = 0;
    int fd_cnt = 0;

    snes_pad_responder #(.NBITS(NBITS), .SYNC_STAGES(2), .DB_CYCLES(DB)) dut (
        .PCLK(PCLK), .PRESERN(PRESERN), .pad_latch(pad_latch), .pad_clk(pad_clk),
        .buttons(buttons), .pad_data(pad_data), .busy(busy), .frame_done(frame_done),
        .bit_idx(bit_idx)
    );

    always #5 PCLK = ~PCLK;

    always @(negedge PCLK) if (frame_done === 1'b1) fd_cnt++;

    task automatic wait_n(input int n);
        repeat (n) @(negedge PCLK);
    endtask

    task automatic latch_pulse(input int len);
        pad_latch = 1'b1;
        wait_n(len);
        pad_latch = 1'b0;
        wait_n(HP);
    endtask

    // host clocks nclk times, sampling pad_data as each falling edge is driven
    task automatic shift_frame(input int nclk, output logic [31:0] got, output logic busy_all, output int idx_bad);
        got = '1;
        busy_all = 1'b1;
        idx_bad = 0;
        for (int k = 0; k < nclk; k++) begin
            pad_clk = 1'b0;
            got[k] = pad_data;
            if (k < NBITS) busy_all = busy_all & busy;
            if (bit_idx !== 5'(k < NBITS ? k : NBITS)) idx_bad++;
            wait_n(HP);
            pad_clk = 1'b1;
            wait_n(HP);
        end
    endtask

    // pressed button k is reported as 0 on the k-th sample; anything beyond the frame reads 1
    function automatic logic [31:0] expect_seq(input logic [NBITS-1:0] b, input int n);
        logic [31:0] e;
        for (int k = 0; k < 32; k++) e[k] = (k < n && k < NBITS) ? ~b[k] : 1'b1;
        return e;
    endfunction

    task automatic test_reset;
        wait_n(3);
        n_cmp++; if (pad_data !== 1'b1) begin n_err++; $display("FAIL reset_pad_data got %b want 1", pad_data); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got %b want 0", busy); end
        n_cmp++; if (frame_done !== 1'b0) begin n_err++; $display("FAIL reset_frame_done got %b want 0", frame_done); end
        n_cmp++; if (bit_idx !== 5'd0) begin n_err++; $display("FAIL reset_bit_idx got %0d want 0", bit_idx); end
        PRESERN = 1'b1;
        wait_n(10);
    endtask

    task automatic test_frame(input logic [NBITS-1:0] b, input int nclk, input int llen);
        logic [31:0] got, exp;
        logic        bz;
        int          ib, fd0, efd, eidx;
        buttons = b;
        wait_n(50);
        fd0 = fd_cnt;
        latch_pulse(llen);
        shift_frame(nclk, got, bz, ib);
        exp  = expect_seq(b, nclk);
        efd  = nclk >= NBITS ? 1 : 0;
        eidx = nclk < NBITS ? nclk : NBITS;
        n_cmp++; if (got !== exp) begin n_err++; $display("FAIL frame_seq b=%h n=%0d got %h want %h", b, nclk, got, exp); end
        n_cmp++; if (fd_cnt - fd0 !== efd) begin n_err++; $display("FAIL frame_done_count b=%h got %0d want %0d", b, fd_cnt - fd0, efd); end
        n_cmp++; if (bit_idx !== 5'(eidx)) begin n_err++; $display("FAIL frame_bit_idx b=%h got %0d want %0d", b, bit_idx, eidx); end
        n_cmp++; if (bz !== 1'b1) begin n_err++; $display("FAIL frame_busy_during b=%h got %b want 1", b, bz); end
        n_cmp++; if (busy !== (nclk < NBITS)) begin n_err++; $display("FAIL frame_busy_after b=%h got %b want %b", b, busy, nclk < NBITS); end
        n_cmp++; if (ib !== 0) begin n_err++; $display("FAIL frame_bit_idx_track b=%h got %0d bad samples want 0", b, ib); end
    endtask

    task automatic test_abort;
        logic [31:0] got;
        logic        bz;
        int          ib, fd0;
        buttons = NBITS'($urandom);
        wait_n(50);
        fd0 = fd_cnt;
        latch_pulse(300);
        shift_frame(5, got, bz, ib);
        buttons = '1;
        pad_latch = 1'b1;
        wait_n(30);
        n_cmp++; if (pad_data !== 1'b0) begin n_err++; $display("FAIL abort_pad_data got %b want 0", pad_data); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL abort_busy got %b want 0", busy); end
        n_cmp++; if (fd_cnt - fd0 !== 0) begin n_err++; $display("FAIL abort_no_done got %0d want 0", fd_cnt - fd0); end
        n_cmp++; if (bit_idx !== 5'd0) begin n_err++; $display("FAIL abort_bit_idx got %0d want 0", bit_idx); end
        wait_n(270);
        pad_latch = 1'b0;
        wait_n(HP);
        shift_frame(NBITS, got, bz, ib);
        n_cmp++; if (got !== expect_seq('1, NBITS)) begin n_err++; $display("FAIL abort_new_frame got %h want %h", got, expect_seq('1, NBITS)); end
        n_cmp++; if (fd_cnt - fd0 !== 1) begin n_err++; $display("FAIL abort_done_count got %0d want 1", fd_cnt - fd0); end
    endtask

    task automatic test_reset_mid_frame;
        logic [31:0] got;
        logic        bz;
        int          ib, fd0;
        buttons = NBITS'($urandom) | 16'h0080;
        wait_n(50);
        latch_pulse(300);
        shift_frame(7, got, bz, ib);
        wait_n(20);
        #3 PRESERN = 1'b0;
        #1;
        n_cmp++; if (pad_data !== 1'b1) begin n_err++; $display("FAIL rst_mid_pad_data got %b want 1", pad_data); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL rst_mid_busy got %b want 0", busy); end
        n_cmp++; if (bit_idx !== 5'd0) begin n_err++; $display("FAIL rst_mid_bit_idx got %0d want 0", bit_idx); end
        @(negedge PCLK) PRESERN = 1'b1;
        wait_n(10);
        fd0 = fd_cnt;
        shift_frame(4, got, bz, ib);
        n_cmp++; if (got[3:0] !== 4'hF) begin n_err++; $display("FAIL rst_mid_no_shift_data got %h want f", got[3:0]); end
        n_cmp++; if (bit_idx !== 5'd0) begin n_err++; $display("FAIL rst_mid_no_shift_idx got %0d want 0", bit_idx); end
        n_cmp++; if (fd_cnt - fd0 !== 0) begin n_err++; $display("FAIL rst_mid_no_done got %0d want 0", fd_cnt - fd0); end
    endtask

`ifdef PAD_DEBOUNCE_EN
    task automatic test_debounce;
        logic [31:0] got;
        logic        bz;
        int          ib;
        buttons = '0;
        wait_n(50);
        buttons[3] = 1'b1;
        wait_n(10);
        buttons[3] = 1'b0;
        latch_pulse(300);
        shift_frame(NBITS, got, bz, ib);
        n_cmp++; if (got[3] !== 1'b1) begin n_err++; $display("FAIL debounce_glitch got %b want 1", got[3]); end
        buttons[3] = 1'b1;
        wait_n(20);
        latch_pulse(300);
        shift_frame(NBITS, got, bz, ib);
        n_cmp++; if (got[3] !== 1'b0) begin n_err++; $display("FAIL debounce_held got %b want 0", got[3]); end
    endtask
`endif

    initial begin
        test_reset;
        test_frame(16'h0001, NBITS, 1000);
        test_frame(16'hA5C3, NBITS, 300);
        test_abort;
        test_frame(NBITS'($urandom), 20, 300);
        for (int r = 0; r < 3; r++) test_frame(NBITS'($urandom), $urandom_range(16, 18), 300);
        test_reset_mid_frame;
`ifdef PAD_DEBOUNCE_EN
        test_debounce;
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
